// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roll sequencer: FSM states,
// die index encoding, sides table, blank digit code and LFSR taps.
package dice_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ROLL   = 3'd1,
      ST_REDUCE = 3'd2,
      ST_BCD    = 3'd3,
      ST_SHOW   = 3'd4
   } state_e;

   localparam logic [2:0] DIE_D4   = 3'd0;
   localparam logic [2:0] DIE_D6   = 3'd1;
   localparam logic [2:0] DIE_D8   = 3'd2;
   localparam logic [2:0] DIE_D10  = 3'd3;
   localparam logic [2:0] DIE_D12  = 3'd4;
   localparam logic [2:0] DIE_D20  = 3'd5;
   localparam logic [2:0] DIE_D100 = 3'd6;

   localparam logic [3:0]  BLANK     = 4'd15;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Sides per die index; entry 0 is d4.
   localparam logic [6:0][6:0] SIDES = {7'd100, 7'd20, 7'd12, 7'd10, 7'd8, 7'd6, 7'd4};

   // Number of sides for a die index; the illegal index 7 maps to 0.
   function automatic logic [6:0] sides_of(input logic [2:0] idx);
      case (idx)
         DIE_D4:   sides_of = SIDES[0];
         DIE_D6:   sides_of = SIDES[1];
         DIE_D8:   sides_of = SIDES[2];
         DIE_D10:  sides_of = SIDES[3];
         DIE_D12:  sides_of = SIDES[4];
         DIE_D20:  sides_of = SIDES[5];
         DIE_D100: sides_of = SIDES[6];
         default:  sides_of = 7'd0;
      endcase
   endfunction

   // Lowest-numbered pressed button wins when several are held.
   function automatic logic [2:0] lowest_btn(input logic [6:0] b);
      lowest_btn = 3'd0;
      for (int i = 6; i >= 0; i--)
         if (b[i]) lowest_btn = 3'(i);
   endfunction

endpackage

// File: rtl/dice_lfsr.sv
// 16-bit Galois LFSR random source. Advances every cycle; while load_i is
// high it reloads seed_i each cycle and so holds that value.
module dice_lfsr
   import dice_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic [15:0] seed_i,
   output logic [15:0] q_o
);

   logic [15:0] lfsr_q, lfsr_d;

   // next state: right shift, fold taps in when the bit shifted out is 1
   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
      if (load_i) lfsr_d = seed_i;
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= SEED;
      else        lfsr_q <= lfsr_d;
   end

   assign q_o = lfsr_q;

endmodule

// File: rtl/dice_roll_ctrl.sv
// Roll sequencer: arbitrates die buttons against I2C roll commands, samples
// the LFSR, reduces by repeated subtraction and converts to two BCD digits.
// Build option DICE_I2C_EN enables the I2C request path; without it the I2C
// inputs are ignored and i2c_ack stays low.
module dice_roll_ctrl
   import dice_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  btn,
   input  logic        i2c_roll,
   input  logic [2:0]  i2c_sides,
   output logic        i2c_ack,
   input  logic        seed_we,
   input  logic [15:0] seed,
   output logic [3:0]  digit1,
   output logic [3:0]  digit10,
   output logic        result_valid,
   output logic        busy
);

   state_e      state_q, state_d;
   logic [2:0]  sel_q, sel_d;       // die being rolled
   logic [6:0]  r_q, r_d;           // sample being reduced
   logic [6:0]  v_q, v_d;           // result 1..100 being split into digits
   logic [3:0]  tens_q, tens_d;
   logic [3:0]  dig1_q, dig1_d, dig10_q, dig10_d;
   logic        ack_q, ack_d;
   logic        pend_q;
   logic [2:0]  pend_sides_q;
   logic        accept;
   logic [15:0] lfsr;
   logic [6:0]  n_sel;

   dice_lfsr #(.SEED(SEED)) u_lfsr (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (seed_we),
      .seed_i (seed),
      .q_o    (lfsr)
   );

   assign n_sel = sides_of(sel_q);

   // FSM, arbitration, reducer and BCD split
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      r_d     = r_q;
      v_d     = v_q;
      tens_d  = tens_q;
      dig1_d  = dig1_q;
      dig10_d = dig10_q;
      ack_d   = 1'b0;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE, ST_SHOW: begin
            if (|btn) begin
               // buttons beat a pending I2C request, which stays pending
               sel_d   = lowest_btn(btn);
               state_d = ST_ROLL;
               dig1_d  = BLANK;
               dig10_d = BLANK;
            end else if (pend_q) begin
               accept = 1'b1;
               ack_d  = 1'b1;
               // index 7 is acknowledged but dropped: nothing else changes
               if (pend_sides_q != 3'd7) begin
                  sel_d   = pend_sides_q;
                  r_d     = lfsr[6:0];
                  state_d = ST_REDUCE;
                  dig1_d  = BLANK;
                  dig10_d = BLANK;
               end
            end
         end
         ST_ROLL: begin
            // only the latched button ends the roll
            if (!btn[sel_q]) begin
               r_d     = lfsr[6:0];
               state_d = ST_REDUCE;
            end
         end
         ST_REDUCE: begin
            if (r_q >= n_sel) begin
               r_d = r_q - n_sel;
            end else begin
               v_d     = r_q + 7'd1;
               tens_d  = 4'd0;
               state_d = ST_BCD;
            end
         end
         ST_BCD: begin
            if (v_q >= 7'd10) begin
               v_d    = v_q - 7'd10;
               tens_d = tens_q + 4'd1;
            end else begin
               // a roll of 100 shows as 00
               dig1_d  = v_q[3:0];
               dig10_d = (tens_q == 4'd10) ? 4'd0 : tens_q;
               state_d = ST_SHOW;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // sequencer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= 3'd0;
         r_q     <= 7'd0;
         v_q     <= 7'd0;
         tens_q  <= 4'd0;
         dig1_q  <= BLANK;
         dig10_q <= BLANK;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         r_q     <= r_d;
         v_q     <= v_d;
         tens_q  <= tens_d;
         dig1_q  <= dig1_d;
         dig10_q <= dig10_d;
         ack_q   <= ack_d;
      end
   end

`ifdef DICE_I2C_EN
   // one-deep pending request; a new command overwrites the die index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q       <= 1'b0;
         pend_sides_q <= 3'd0;
      end else if (i2c_roll) begin
         pend_q       <= 1'b1;
         pend_sides_q <= i2c_sides;
      end else if (accept) begin
         pend_q       <= 1'b0;
      end
   end
`else
   // no I2C source: nothing is ever pending, so ack_q never sets
   assign pend_q       = 1'b0;
   assign pend_sides_q = 3'd0;
   logic unused_i2c;
   assign unused_i2c = ^{i2c_roll, i2c_sides, accept};
`endif

   assign i2c_ack      = ack_q;
   assign digit1       = dig1_q;
   assign digit10      = dig10_q;
   assign result_valid = (state_q == ST_SHOW);
   assign busy         = (state_q == ST_ROLL) || (state_q == ST_REDUCE) || (state_q == ST_BCD);

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Self-checking bench for dice_roll_ctrl: reset values, table of button rolls,
// randomized rolls against an arithmetic model, corner-case sequences, and the
// I2C path (or its absence, depending on DICE_I2C_EN).
module tb_dice_roll_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  btn = '0;
   logic        i2c_roll = 1'b0;
   logic [2:0]  i2c_sides = '0;
   logic        i2c_ack;
   logic        seed_we = 1'b0;
   logic [15:0] seed = '0;
   logic [3:0]  digit1, digit10;
   logic        result_valid, busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dice_roll_ctrl #(.SEED(16'hACE1)) dut (
      .clk(clk), .rst_n(rst_n), .btn(btn), .i2c_roll(i2c_roll), .i2c_sides(i2c_sides),
      .i2c_ack(i2c_ack), .seed_we(seed_we), .seed(seed), .digit1(digit1), .digit10(digit10),
      .result_valid(result_valid), .busy(busy)
   );

   typedef struct {
      logic [15:0] s;
      logic [6:0]  m;
      int          d10;
      int          d1;
   } vec_t;
   vec_t vecs[$];

   // ---------------- reference model ----------------
   function automatic int n_of(input int idx);
      case (idx)
         0: return 4;   1: return 6;   2: return 8;   3: return 10;
         4: return 12;  5: return 20;  6: return 100;
         default: return 0;
      endcase
   endfunction

   function automatic int low_idx(input logic [6:0] m);
      for (int i = 0; i < 7; i++) if (m[i]) return i;
      return 0;
   endfunction

   function automatic logic [15:0] lfsr_step(input logic [15:0] x);
      return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic int exp_v(input int r, input int idx);
      return (r % n_of(idx)) + 1;
   endfunction

   function automatic int exp_d10(input int v);
      return (v == 100) ? 0 : v / 10;
   endfunction

   // cycles spent in reduce plus digit conversion
   function automatic int exp_cyc(input int r, input int idx);
      return (r / n_of(idx) + 1) + (exp_v(r, idx) / 10 + 1);
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic wait_rv(input int n0, output int n);
      n = n0;
      while (!result_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic check_res(input string nm, input int lat, input int elat,
                            input int e10, input int e1);
      chk({nm, "_lat"}, lat, elat);
      chk({nm, "_d10"}, digit10, e10);
      chk({nm, "_d1"}, digit1, e1);
      chk({nm, "_busy"}, busy, 0);
   endtask

   // press m with seed held at s, release, wait for the result
   task automatic btn_roll(input logic [15:0] s, input logic [6:0] m, output int lat);
      @(negedge clk);
      seed_we = 1'b1; seed = s; btn = m;
      repeat (3) @(negedge clk);
      chk("roll_busy", busy, 1);
      chk("roll_blank", {digit10, digit1}, 8'hFF);
      btn = '0;
      wait_rv(0, lat);
   endtask

`ifdef DICE_I2C_EN
   task automatic i2c_case(input string nm, input logic [15:0] s, input logic [2:0] sd);
      int lat, r, v;
      @(negedge clk);
      seed_we = 1'b1; seed = s; i2c_roll = 1'b1; i2c_sides = sd;
      @(negedge clk);
      i2c_roll = 1'b0;
      chk({nm, "_ack_early"}, i2c_ack, 0);
      @(negedge clk);
      chk({nm, "_ack"}, i2c_ack, 1);
      chk({nm, "_busy_on"}, busy, 1);
      @(negedge clk);
      chk({nm, "_ack_single"}, i2c_ack, 0);
      wait_rv(3, lat);
      r = int'(s[6:0]);
      v = exp_v(r, sd);
      check_res(nm, lat, 2 + exp_cyc(r, sd), exp_d10(v), v % 10);
   endtask
`endif

   // ---------------- test sequence ----------------
   initial begin
      int lat, r, v, idx, k, acks, busies;
      logic [15:0] s, x;
      logic [6:0]  m;

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_digit1", digit1, 15);
      chk("rst_digit10", digit10, 15);
      chk("rst_valid", result_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ack", i2c_ack, 0);

      // first roll from the reset seed, LFSR free-running
      rst_n = 1'b1; btn = 7'b0001000;
      @(negedge clk);
      repeat (4) @(negedge clk);
      btn = '0;
      wait_rv(0, lat);
      x = 16'hACE1;
      repeat (5) x = lfsr_step(x);
      r = int'(x[6:0]);
      v = exp_v(r, 3);
      check_res("seed_rst", lat, 1 + exp_cyc(r, 3), exp_d10(v), v % 10);

      // table of button rolls with seed held
      vecs.push_back('{16'h0061, 7'b0100100, 0, 2});
      vecs.push_back('{16'h0061, 7'b0001000, 0, 8});
      vecs.push_back('{16'h0061, 7'b1000000, 9, 8});
      vecs.push_back('{16'h0061, 7'b0000001, 0, 2});
      vecs.push_back('{16'h0063, 7'b1000000, 0, 0});
      vecs.push_back('{16'h007F, 7'b0000001, 0, 4});
      vecs.push_back('{16'h0000, 7'b0100000, 0, 1});
      vecs.push_back('{16'h0013, 7'b0100000, 2, 0});
      vecs.push_back('{16'h000C, 7'b0010000, 0, 1});
      vecs.push_back('{16'h005F, 7'b1000000, 9, 6});
      vecs.push_back('{16'hFF09, 7'b0000010, 0, 4});
      vecs.push_back('{16'h0064, 7'b1000000, 0, 1});
      foreach (vecs[i]) begin
         btn_roll(vecs[i].s, vecs[i].m, lat);
         r = int'(vecs[i].s[6:0]);
         check_res($sformatf("tbl%0d", i), lat, 1 + exp_cyc(r, low_idx(vecs[i].m)),
                   vecs[i].d10, vecs[i].d1);
      end

      // random rolls, seed held
      for (int i = 0; i < 16; i++) begin
         s = 16'($urandom);
         m = 7'($urandom_range(1, 127));
         btn_roll(s, m, lat);
         r = int'(s[6:0]); idx = low_idx(m); v = exp_v(r, idx);
         check_res($sformatf("rnd%0d", i), lat, 1 + exp_cyc(r, idx), exp_d10(v), v % 10);
      end

      // random rolls with the LFSR running for k cycles after loading
      for (int i = 0; i < 8; i++) begin
         s = 16'($urandom);
         m = 7'($urandom_range(1, 127));
         k = int'($urandom_range(1, 20));
         @(negedge clk);
         seed_we = 1'b1; seed = s; btn = m;
         @(negedge clk);
         seed_we = 1'b0;
         repeat (k) @(negedge clk);
         btn = '0;
         wait_rv(0, lat);
         x = s;
         repeat (k) x = lfsr_step(x);
         r = int'(x[6:0]); idx = low_idx(m); v = exp_v(r, idx);
         check_res($sformatf("adv%0d", i), lat, 1 + exp_cyc(r, idx), exp_d10(v), v % 10);
      end

      // other buttons ignored during a roll
      @(negedge clk);
      seed_we = 1'b1; seed = 16'h0061; btn = 7'b0000100;
      @(negedge clk); btn = 7'b0100100;
      @(negedge clk); btn = 7'b0000100;
      @(negedge clk);
      chk("ign_busy", busy, 1);
      chk("ign_valid", result_valid, 0);
      btn = '0;
      wait_rv(0, lat);
      check_res("ign", lat, 1 + exp_cyc(97, 2), 0, 2);

`ifdef DICE_I2C_EN
      i2c_case("i2c_d10", 16'h0061, 3'd3);
      i2c_case("i2c_d100", 16'h0061, 3'd6);
      i2c_case("i2c_d4", 16'h0061, 3'd0);
      i2c_case("i2c_100", 16'h0063, 3'd6);

      // button and I2C in the same cycle: button first, then I2C from SHOW
      @(negedge clk);
      seed_we = 1'b1; seed = 16'h0061; btn = 7'b0000001; i2c_roll = 1'b1; i2c_sides = 3'd5;
      @(negedge clk); i2c_roll = 1'b0;
      @(negedge clk); @(negedge clk); btn = '0;
      acks = 0; lat = 0;
      while (!result_valid && lat < 300) begin
         @(negedge clk); lat++;
         if (i2c_ack) acks++;
      end
      check_res("bi_btn", lat, 1 + exp_cyc(97, 0), 0, 2);
      chk("bi_no_ack_busy", acks, 0);
      @(negedge clk);
      chk("bi_ack", i2c_ack, 1);
      chk("bi_busy", busy, 1);
      wait_rv(0, lat);
      check_res("bi_i2c", lat, exp_cyc(97, 5), 1, 8);

      // two requests while busy: the later die index wins
      @(negedge clk);
      seed = 16'h007F; btn = 7'b0000001;
      repeat (2) @(negedge clk);
      btn = '0;
      repeat (3) @(negedge clk);
      i2c_roll = 1'b1; i2c_sides = 3'd1;
      @(negedge clk); i2c_roll = 1'b0;
      @(negedge clk); i2c_roll = 1'b1; i2c_sides = 3'd4;
      @(negedge clk); i2c_roll = 1'b0;
      acks = 0; lat = 0;
      while (!result_valid && lat < 300) begin
         @(negedge clk); lat++;
         if (i2c_ack) acks++;
      end
      chk("two_d10", digit10, 0);
      chk("two_d1", digit1, 4);
      chk("two_no_ack_busy", acks, 0);
      @(negedge clk);
      chk("two_ack", i2c_ack, 1);
      wait_rv(0, lat);
      check_res("two_d12", lat, exp_cyc(127, 4), 0, 8);
      acks = 0; busies = 0;
      repeat (4) begin
         @(negedge clk);
         if (i2c_ack) acks++;
         if (busy) busies++;
      end
      chk("two_once_ack", acks, 0);
      chk("two_once_busy", busies, 0);

      // illegal die index: acknowledged, result left as is
      @(negedge clk); i2c_roll = 1'b1; i2c_sides = 3'd7;
      @(negedge clk); i2c_roll = 1'b0;
      @(negedge clk);
      chk("ill_ack", i2c_ack, 1);
      chk("ill_busy", busy, 0);
      chk("ill_valid", result_valid, 1);
      chk("ill_digits", {digit10, digit1}, 8'h08);
`else
      // without the I2C path, commands do nothing
      acks = 0; busies = 0;
      @(negedge clk); i2c_roll = 1'b1; i2c_sides = 3'd3;
      @(negedge clk); i2c_roll = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (i2c_ack) acks++;
         if (busy) busies++;
      end
      chk("noi2c_ack", acks, 0);
      chk("noi2c_busy", busies, 0);
      chk("noi2c_valid", result_valid, 1);
`endif

      // asynchronous reset in the middle of a reduction drops everything
      @(negedge clk);
      seed_we = 1'b1; seed = 16'h007F; btn = 7'b0000001;
      repeat (2) @(negedge clk);
      btn = '0;
      repeat (5) @(negedge clk);
      i2c_roll = 1'b1; i2c_sides = 3'd3;
      @(negedge clk); i2c_roll = 1'b0;
      chk("mid_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_digit1", digit1, 15);
      chk("mid_rst_digit10", digit10, 15);
      chk("mid_rst_valid", result_valid, 0);
      chk("mid_rst_busy", busy, 0);
      @(negedge clk); rst_n = 1'b1;
      acks = 0; busies = 0;
      repeat (6) begin
         @(negedge clk);
         if (i2c_ack) acks++;
         if (busy) busies++;
      end
      chk("mid_pend_lost", acks, 0);
      chk("mid_idle", busies, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

endmodule
